// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer between pcreg and imem: boots the PC, fetches one word per
// req/ready handshake, then advances or redirects the PC. Stalls and imem timeouts are also handled here.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          TIMEOUT  = 15,
  parameter int          CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err,
  output logic        fetch_err
);

  typedef enum logic [2:0] {S_BOOT, S_REQ, S_UPD, S_HOLD, S_ERR} state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             pend_valid_reg;
  logic [31:0]      pend_target_reg;
  logic             pc_ena_reg;
  logic             imem_req_reg;
  logic             instr_valid_reg;
  logic [31:0]      instr_reg;
  logic [31:0]      instr_pc_reg;
  logic             misalign_err_reg;
  logic             fetch_err_reg;

  logic             branch_ok;
  logic [31:0]      upd_target;

  assign branch_ok = branch_valid && (branch_target[1:0] == 2'b00);

  // A branch arriving in the UPD cycle itself beats any earlier pending one.
  always_comb begin
    upd_target = pc_cur + 32'd4;
    if (branch_ok)
      upd_target = branch_target;
    else if (pend_valid_reg)
      upd_target = pend_target_reg;
  end

  assign pc_next      = (state_reg == S_UPD) ? upd_target : RESET_PC;
  assign pc_ena       = pc_ena_reg;
  assign imem_req     = imem_req_reg;
  assign imem_addr    = pc_cur;
  assign instr_valid  = instr_valid_reg;
  assign instr        = instr_reg;
  assign instr_pc     = instr_pc_reg;
  assign misalign_err = misalign_err_reg;
  assign fetch_err    = fetch_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_BOOT;
      wait_cnt_reg     <= '0;
      pend_valid_reg   <= 1'b0;
      pend_target_reg  <= '0;
      pc_ena_reg       <= 1'b1;
      imem_req_reg     <= 1'b0;
      instr_valid_reg  <= 1'b0;
      instr_reg        <= '0;
      instr_pc_reg     <= '0;
      misalign_err_reg <= 1'b0;
      fetch_err_reg    <= 1'b0;
    end else begin
      instr_valid_reg <= 1'b0;
      pc_ena_reg      <= 1'b0;

      if (state_reg != S_ERR && branch_valid) begin
        if (branch_ok) begin
          pend_valid_reg  <= 1'b1;
          pend_target_reg <= branch_target;
        end else begin
          misalign_err_reg <= 1'b1;
        end
      end

      case (state_reg)
        S_BOOT: begin
          state_reg    <= S_REQ;
          imem_req_reg <= 1'b1;
          wait_cnt_reg <= '0;
        end
        S_REQ: begin
          if (imem_ready) begin
            instr_reg       <= imem_rdata;
            instr_pc_reg    <= pc_cur;
            instr_valid_reg <= 1'b1;
            pc_ena_reg      <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= S_UPD;
          end else if (wait_cnt_reg == WAIT_LAST) begin
            imem_req_reg  <= 1'b0;
            fetch_err_reg <= 1'b1;
            state_reg     <= S_ERR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        S_UPD: begin
          // The pending target (or this cycle's branch) is consumed by pc_next now.
          pend_valid_reg <= 1'b0;
          if (stall) begin
            state_reg <= S_HOLD;
          end else begin
            state_reg    <= S_REQ;
            imem_req_reg <= 1'b1;
            wait_cnt_reg <= '0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            state_reg    <= S_REQ;
            imem_req_reg <= 1'b1;
            wait_cnt_reg <= '0;
          end
        end
        S_ERR: begin
          state_reg <= S_ERR;
        end
        default: begin
          state_reg <= S_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a pcreg model, an imem model and a
// scoreboard of accepted fetches checked against each instr_valid pulse.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] RDATA_BASE = 32'h2008_0005;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur = 32'h0;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        stall = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;
  logic        fetch_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];

  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_ena(pc_ena), .pc_next(pc_next),
    .stall(stall), .branch_valid(branch_valid), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .misalign_err(misalign_err), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // pcreg model and imem data model (word depends on address so each fetch is distinct)
  always @(posedge clk) if (pc_ena) pc_cur <= pc_next;
  assign imem_rdata = RDATA_BASE ^ imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on handshake, pop on instr_valid.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (instr_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_valid", {31'b0, instr_valid}, 32'h0);
        end else begin
          logic [63:0] e;
          e = sb_q.pop_front();
          check("sb_instr", instr, e[31:0]);
          check("sb_instr_pc", instr_pc, e[63:32]);
          $display("txn: pc=%h instr=%h", instr_pc, instr);
        end
      end
      if (imem_req && imem_ready)
        sb_q.push_back({imem_addr, RDATA_BASE ^ imem_addr});
    end
  end

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output logic [31:0] a, output int n);
    n = 0;
    a = 32'h0;
    forever begin
      @(negedge clk);
      n++;
      if (imem_req && imem_ready) begin
        a = imem_addr;
        break;
      end
      if (n >= 40) begin
        check("accept_timeout", {31'b0, imem_req && imem_ready}, 32'h1);
        break;
      end
    end
  endtask

  logic [31:0] a;
  int          n;
  int          req_cycles;
  logic [31:0] exp_seq[3];

  initial begin
    exp_seq[0] = 32'h0040_0000;
    exp_seq[1] = 32'h0040_0004;
    exp_seq[2] = 32'h0040_0008;

    // Reset for two cycles, then BOOT and the first request
    @(posedge clk);
    @(negedge clk);
    check("rst_pc_ena", {31'b0, pc_ena}, 32'h1);
    check("rst_pc_next", pc_next, RST_PC);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_errs", {30'b0, misalign_err, fetch_err}, 32'h0);
    drive();
    rst = 1'b0;
    @(negedge clk);
    check("boot_pc_ena", {31'b0, pc_ena}, 32'h1);
    check("boot_pc_next", pc_next, RST_PC);
    check("boot_no_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, RST_PC);

    // Back-to-back fetches with imem always ready
    drive();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_accept(a, n);
      check("seq_addr", a, exp_seq[i]);
      if (i > 0) check("req_after_valid", n, 1);
      @(negedge clk);
      check("seq_valid", {31'b0, instr_valid}, 32'h1);
      check("seq_upd_pc_ena", {31'b0, pc_ena}, 32'h1);
    end

    // Aligned branch during a REQ wait redirects the following fetch
    drive();
    imem_ready    = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 32'h0040_0100;
    drive();
    branch_valid = 1'b0;
    imem_ready   = 1'b1;
    wait_accept(a, n);
    check("pre_branch_addr", a, 32'h0040_000C);
    @(negedge clk);
    check("branch_pc_next", pc_next, 32'h0040_0100);
    wait_accept(a, n);
    check("branch_addr", a, 32'h0040_0100);

    // Branch in the UPD cycle applies at once; a misaligned one is dropped
    drive();
    imem_ready    = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 32'h0040_0000;
    @(negedge clk);
    check("upd_branch_pc_next", pc_next, 32'h0040_0000);
    drive();
    branch_target = 32'h0040_0102;
    drive();
    branch_valid = 1'b0;
    imem_ready   = 1'b1;
    wait_accept(a, n);
    check("upd_branch_addr", a, 32'h0040_0000);
    check("misalign_err", {31'b0, misalign_err}, 32'h1);
    wait_accept(a, n);
    check("misalign_seq_addr", a, 32'h0040_0004);

    // Stall across UPD holds off requests; stall in REQ does not drop it
    drive();
    stall      = 1'b1;
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_no_req", {31'b0, imem_req}, 32'h0);
    end
    drive();
    stall = 1'b0;
    @(negedge clk);
    check("unstall_not_yet", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    check("unstall_req", {31'b0, imem_req}, 32'h1);
    check("unstall_addr", imem_addr, 32'h0040_0008);
    drive();
    stall = 1'b1;
    @(negedge clk);
    check("stall_in_req", {31'b0, imem_req}, 32'h1);
    drive();
    stall      = 1'b0;
    imem_ready = 1'b1;
    wait_accept(a, n);
    check("after_stall_addr", a, 32'h0040_0008);

    // Timeout: imem never ready
    drive();
    imem_ready = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
      else if (req_cycles > 0) break;
    end
    check("timeout_req_cycles", req_cycles, 15);
    check("timeout_fetch_err", {31'b0, fetch_err}, 32'h1);
    check("timeout_req_low", {31'b0, imem_req}, 32'h0);
    drive();
    imem_ready    = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 32'h0000_0100;
    drive();
    branch_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("err_stuck", {29'b0, imem_req, pc_ena, fetch_err}, 32'h1);
    end

    // Reset out of ERR, then walk through the 0xFFFFFFFC wrap
    drive();
    rst        = 1'b1;
    imem_ready = 1'b0;
    drive();
    rst           = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    check("rst2_fetch_err", {31'b0, fetch_err}, 32'h0);
    drive();
    branch_valid = 1'b0;
    imem_ready   = 1'b1;
    wait_accept(a, n);
    check("rst2_addr", a, RST_PC);
    @(negedge clk);
    check("wrap_branch_pc_next", pc_next, 32'hFFFF_FFFC);
    wait_accept(a, n);
    check("wrap_fetch_addr", a, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc_next", pc_next, 32'h0000_0000);
    wait_accept(a, n);
    check("wrap_addr", a, 32'h0000_0000);

    // Reset in the middle of a REQ wait
    drive();
    imem_ready = 1'b0;
    drive();
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_req", {31'b0, imem_req}, 32'h1);
    drive();
    rst = 1'b0;
    check("midrst_req", {31'b0, imem_req}, 32'h0);
    check("midrst_pc_next", pc_next, RST_PC);
    check("midrst_pc_ena", {31'b0, pc_ena}, 32'h1);
    check("midrst_instr", instr, 32'h0);
    check("midrst_instr_pc", instr_pc, 32'h0);
    check("midrst_flags", {29'b0, instr_valid, misalign_err, fetch_err}, 32'h0);
    imem_ready = 1'b1;
    wait_accept(a, n);
    check("midrst_refetch_addr", a, RST_PC);
    check("midrst_refetch_lat", n, 2);
    @(negedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
